// File: rtl/iq_pkg.sv
// Shared types and constants for the instruction issue queue.
// Entry layout is {type, dest, src1, src2}, oldest field in the MSBs.
package iq_pkg;

  localparam int FIELD_W_DEF = 8;

  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_ONE  = 2'd1;
  localparam logic [1:0] POP_TWO  = 2'd2;

  typedef struct packed {
    logic [FIELD_W_DEF-1:0] typ;
    logic [FIELD_W_DEF-1:0] dest;
    logic [FIELD_W_DEF-1:0] src1;
    logic [FIELD_W_DEF-1:0] src2;
  } inst_t;

  // A 2-bit count of 3 is clamped to 2.
  function automatic logic [1:0] sat2(input logic [1:0] v);
    return (v == 2'b11) ? POP_TWO : v;
  endfunction

endpackage

// File: rtl/iq_ptr_wrap.sv
// Circular pointer advance: nxt = (ptr + k) mod DEPTH, k in 0..2.
// Wrap is an explicit compare, so DEPTH need not be a power of two.
module iq_ptr_wrap #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic [1:0]       k,
  output logic [PTR_W-1:0] nxt
);

  logic at_last;
  logic at_pen;

  assign at_last = (ptr == PTR_W'(DEPTH - 1));
  assign at_pen  = (ptr == PTR_W'(DEPTH - 2));

  always_comb begin
    nxt = ptr;
    unique case (k)
      2'd1: nxt = at_last ? '0 : ptr + PTR_W'(1);
      2'd2: begin
        if (at_pen)
          nxt = '0;
        else if (at_last)
          nxt = PTR_W'(1);
        else
          nxt = ptr + PTR_W'(2);
      end
      default: nxt = ptr;
    endcase
  end

endmodule

// File: rtl/inst_issue_queue.sv
// Dual-in/dual-out circular instruction queue feeding Tomasulo issue.
// Optional IQ_FULL_STALL_CNT_EN adds a saturating full-stall counter.
module inst_issue_queue #(
  parameter int FIELD_W = iq_pkg::FIELD_W_DEF,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [1:0]         push_cnt,
  input  logic [4*FIELD_W-1:0] push_inst0,
  input  logic [4*FIELD_W-1:0] push_inst1,
  output logic               fetch_ready,
  input  logic [1:0]         select_instruction,
  output logic               inst1_valid,
  output logic               inst2_valid,
  output logic [FIELD_W-1:0] inst1_type,
  output logic [FIELD_W-1:0] inst1_destination_reg,
  output logic [FIELD_W-1:0] inst1_source_reg1,
  output logic [FIELD_W-1:0] inst1_source_reg2,
  output logic [FIELD_W-1:0] inst2_type,
  output logic [FIELD_W-1:0] inst2_destination_reg,
  output logic [FIELD_W-1:0] inst2_source_reg1,
  output logic [FIELD_W-1:0] inst2_source_reg2,
  output logic [CNT_W-1:0]   occupancy
`ifdef IQ_FULL_STALL_CNT_EN
  ,
  output logic [31:0]        full_stall_cnt
`endif
);

  import iq_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [FIELD_W-1:0] typ;
    logic [FIELD_W-1:0] dest;
    logic [FIELD_W-1:0] src1;
    logic [FIELD_W-1:0] src2;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] tail_nxt;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] free;
  logic [1:0]       pcnt;
  logic [1:0]       sel;
  logic [1:0]       pop;
  logic [1:0]       push_acc;
  logic             push_ok;
  entry_t           e1;
  entry_t           e2;

  iq_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_p1 (
    .ptr (head),
    .k   (POP_ONE),
    .nxt (head_p1)
  );

  iq_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_adv (
    .ptr (head),
    .k   (pop),
    .nxt (head_nxt)
  );

  iq_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_p1 (
    .ptr (tail),
    .k   (POP_ONE),
    .nxt (tail_p1)
  );

  iq_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_adv (
    .ptr (tail),
    .k   (push_acc),
    .nxt (tail_nxt)
  );

  // Space is judged on pre-pop occupancy, so overflow cannot occur.
  always_comb begin
    pcnt     = (push_cnt == 2'b11) ? POP_NONE : push_cnt;
    sel      = sat2(select_instruction);
    pop      = (occ >= CNT_W'(sel)) ? sel : occ[1:0];
    free     = CNT_W'(DEPTH) - occ;
    push_ok  = (free >= CNT_W'(pcnt));
    push_acc = push_ok ? pcnt : POP_NONE;
  end

  assign fetch_ready = (free >= CNT_W'(2));
  assign occupancy   = occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      occ  <= occ + CNT_W'(push_acc) - CNT_W'(pop);
      if (push_acc != POP_NONE)
        mem[tail] <= entry_t'(push_inst0);
      if (push_acc == POP_TWO)
        mem[tail_p1] <= entry_t'(push_inst1);
    end
  end

  always_comb begin
    inst1_valid = (occ >= CNT_W'(1));
    inst2_valid = (occ >= CNT_W'(2));
    e1 = inst1_valid ? mem[head]    : '0;
    e2 = inst2_valid ? mem[head_p1] : '0;
  end

  assign inst1_type            = e1.typ;
  assign inst1_destination_reg = e1.dest;
  assign inst1_source_reg1     = e1.src1;
  assign inst1_source_reg2     = e1.src2;
  assign inst2_type            = e2.typ;
  assign inst2_destination_reg = e2.dest;
  assign inst2_source_reg1     = e2.src1;
  assign inst2_source_reg2     = e2.src2;

`ifdef IQ_FULL_STALL_CNT_EN
  // Counts rejected offers only; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      full_stall_cnt <= '0;
    else if (pcnt != POP_NONE && !push_ok && full_stall_cnt != '1)
      full_stall_cnt <= full_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_inst_issue_queue.sv
// Randomized + directed bench for inst_issue_queue against a queue model.
// Build with +define+IQ_FULL_STALL_CNT_EN to also check the stall counter.
module tb_inst_issue_queue;

  localparam int FW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [1:0]    push_cnt;
  logic [4*FW-1:0] push_inst0;
  logic [4*FW-1:0] push_inst1;
  logic          fetch_ready;
  logic [1:0]    select_instruction;
  logic          inst1_valid;
  logic          inst2_valid;
  logic [FW-1:0] inst1_type;
  logic [FW-1:0] inst1_destination_reg;
  logic [FW-1:0] inst1_source_reg1;
  logic [FW-1:0] inst1_source_reg2;
  logic [FW-1:0] inst2_type;
  logic [FW-1:0] inst2_destination_reg;
  logic [FW-1:0] inst2_source_reg1;
  logic [FW-1:0] inst2_source_reg2;
  logic [CW-1:0] occupancy;
`ifdef IQ_FULL_STALL_CNT_EN
  logic [31:0]   full_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] q [$];
  logic [31:0] m_stall = 0;
  int          seq = 0;

  always #5 clk = ~clk;

  inst_issue_queue #(.FIELD_W(FW), .DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .flush                 (flush),
    .push_cnt              (push_cnt),
    .push_inst0            (push_inst0),
    .push_inst1            (push_inst1),
    .fetch_ready           (fetch_ready),
    .select_instruction    (select_instruction),
    .inst1_valid           (inst1_valid),
    .inst2_valid           (inst2_valid),
    .inst1_type            (inst1_type),
    .inst1_destination_reg (inst1_destination_reg),
    .inst1_source_reg1     (inst1_source_reg1),
    .inst1_source_reg2     (inst1_source_reg2),
    .inst2_type            (inst2_type),
    .inst2_destination_reg (inst2_destination_reg),
    .inst2_source_reg1     (inst2_source_reg1),
    .inst2_source_reg2     (inst2_source_reg2),
    .occupancy             (occupancy)
`ifdef IQ_FULL_STALL_CNT_EN
    ,
    .full_stall_cnt        (full_stall_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {b, ~b, b ^ 8'h5a, b + 8'd3};
  endfunction

  task automatic check_out();
    logic [31:0] e1;
    logic [31:0] e2;
    e1 = '0;
    e2 = '0;
    if (q.size() >= 1) e1 = q[0];
    if (q.size() >= 2) e2 = q[1];
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("inst1_valid", 64'(inst1_valid), 64'(q.size() >= 1));
    chk("inst2_valid", 64'(inst2_valid), 64'(q.size() >= 2));
    chk("fetch_ready", 64'(fetch_ready),
        64'((DEPTH - q.size()) >= 2));
    chk("inst1", 64'({inst1_type, inst1_destination_reg,
                      inst1_source_reg1, inst1_source_reg2}),
        64'(e1));
    chk("inst2", 64'({inst2_type, inst2_destination_reg,
                      inst2_source_reg1, inst2_source_reg2}),
        64'(e2));
`ifdef IQ_FULL_STALL_CNT_EN
    chk("full_stall_cnt", 64'(full_stall_cnt), 64'(m_stall));
`endif
  endtask

  // Reference: pop min(sel,size), push all-or-nothing on pre-pop space.
  task automatic model_update(input logic fl, input logic [1:0] pc,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] s);
    int sz;
    int pn;
    int sn;
    int np;
    bit ok;
    sz = q.size();
    pn = (pc == 2'd3) ? 0 : int'(pc);
    sn = (s == 2'd3) ? 2 : int'(s);
    ok = (DEPTH - sz) >= pn;
    if (pn != 0 && !ok && m_stall != 32'hFFFF_FFFF)
      m_stall = m_stall + 1;
    if (fl) begin
      q.delete();
    end else begin
      np = (sn < sz) ? sn : sz;
      for (int i = 0; i < np; i++)
        void'(q.pop_front());
      if (ok && pn >= 1) q.push_back(a);
      if (ok && pn == 2) q.push_back(b);
    end
  endtask

  task automatic step(input logic fl, input logic [1:0] pc,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] s);
    flush = fl;
    push_cnt = pc;
    push_inst0 = a;
    push_inst1 = b;
    select_instruction = s;
    #2;
    check_out();
    @(posedge clk);
    model_update(fl, pc, a, b, s);
    #1;
  endtask

  task automatic push2(input logic [1:0] s);
    step(1'b0, 2'd2, mk(seq), mk(seq + 1), s);
    seq += 2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b1;
    push_cnt = 2'd2;
    push_inst0 = $urandom;
    push_inst1 = $urandom;
    select_instruction = 2'd3;
    q.delete();
    m_stall = 0;
    #2;
    check_out();
    @(posedge clk);
    #1;
    check_out();
    rst_n = 1'b1;
  endtask

  initial begin
`ifdef IQ_FULL_STALL_CNT_EN
    logic [31:0] base;
`endif
    rst_n = 1'b1;
    #1;
    do_reset();

    for (int i = 0; i < 8; i++)
      push2(2'd0);
    chk("fill_occ", 64'(occupancy), 64'(DEPTH));
    chk("fill_ready", 64'(fetch_ready), 64'(0));
    push2(2'd0);
    chk("reject_occ", 64'(occupancy), 64'(DEPTH));

    for (int i = 0; i < 8; i++) begin
      chk("drain_head", 64'({inst1_type, inst1_destination_reg,
                             inst1_source_reg1, inst1_source_reg2}),
          64'(mk(2 * i)));
      step(1'b0, 2'd0, 32'h0, 32'h0, 2'b10);
    end
    chk("drain_occ", 64'(occupancy), 64'(0));
    chk("drain_v2", 64'(inst2_valid), 64'(0));

    for (int i = 0; i < 7; i++) push2(2'd0);
    for (int i = 0; i < 7; i++)
      step(1'b0, 2'd0, 32'h0, 32'h0, 2'd2);
    push2(2'd0);
    step(1'b0, 2'd1, mk(seq), 32'h0, 2'd0);
    seq++;
    for (int i = 0; i < 10; i++) begin
      push2(2'd2);
      chk("wrap_occ", 64'(occupancy), 64'(3));
    end

    step(1'b0, 2'd0, 32'h0, 32'h0, 2'd2);
    chk("overpop_pre", 64'(occupancy), 64'(1));
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'b10);
    chk("overpop_1", 64'(occupancy), 64'(0));
    push2(2'd0);
    push2(2'd0);
    step(1'b0, 2'd1, mk(seq), 32'h0, 2'd0);
    seq++;
    step(1'b0, 2'd0, 32'h0, 32'h0, 2'b11);
    chk("overpop_3", 64'(occupancy), 64'(3));

    push2(2'd1);
    step(1'b1, 2'd2, mk(seq), mk(seq + 1), 2'd1);
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_v1", 64'(inst1_valid), 64'(0));

`ifdef IQ_FULL_STALL_CNT_EN
    for (int i = 0; i < 8; i++) push2(2'd0);
    base = full_stall_cnt;
    for (int i = 0; i < 5; i++) push2(2'd0);
    chk("stall5", 64'(full_stall_cnt), 64'(base + 32'd5));
    step(1'b1, 2'd0, 32'h0, 32'h0, 2'd0);
    chk("stall_keep", 64'(full_stall_cnt), 64'(base + 32'd5));
`endif

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 31) == 0,
             2'($urandom_range(0, 3)),
             $urandom, $urandom,
             2'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
